// File: rtl/div_pkg.sv
// Shared width, FSM state encoding and divide-by-zero constant for the
// two-requester divider arbiter.
package div_pkg;

  localparam int WIDTH     = 5;
  localparam int MAX_WIDTH = 32;

  // Quotient reported on divide-by-zero; truncated to the instance width.
  localparam logic [MAX_WIDTH-1:0] DZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_core.sv
// Iterative restoring unsigned divider: one shift/subtract step per clock,
// WIDTH steps per operation. q/r present the values after the current step.
module div_core #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  import div_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // rem < dvs always holds, so the shifted value fits in WIDTH+1 bits and the
  // restored remainder fits back into WIDTH bits.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs});
    rem_nxt = fits ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (start) begin
      cnt <= CW'(WIDTH);
      rem <= '0;
      quo <= a;
      dvs <= b;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

  assign done = (cnt == CW'(1));
  assign q    = quo_nxt;
  assign r    = rem_nxt;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between two requesters.
//   state | meaning
//   IDLE  | ready offered to the granted valid requester
//   RUN   | divider stepping, requests ignored
//   DONE  | response held until rsp_ready
module div_arbiter #(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_q,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_dz,
  input  logic             rsp_ready
);
  import div_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             cur_id;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             by_zero;
  logic             start;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             core_done;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_r;

  // prio names the requester that wins the next tie.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && (!req1_valid || !prio)) grant0 = 1'b1;
      else if (req1_valid)                      grant1 = 1'b1;
    end
    accept  = grant0 | grant1;
    sel_a   = grant1 ? req1_a : req0_a;
    sel_b   = grant1 ? req1_b : req0_b;
    by_zero = (sel_b == '0);
    start   = accept && !by_zero;
    case (state)
      IDLE:    if (accept) state_nxt = by_zero ? DONE : RUN;
      RUN:     if (core_done) state_nxt = DONE;
      DONE:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A divide-by-zero enters DONE at the accept edge but raises rsp_valid one
  // edge later, so its latency is a single edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio      <= 1'b0;
      cur_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dz    <= 1'b0;
    end else begin
      if (accept) begin
        prio   <= grant0;
        cur_id <= grant1;
        if (by_zero) begin
          rsp_id <= grant1;
          rsp_q  <= WIDTH'(DZ_QUOT);
          rsp_r  <= sel_a;
          rsp_dz <= 1'b1;
        end
      end
      if (state == RUN && core_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= cur_id;
        rsp_q     <= core_q;
        rsp_r     <= core_r;
        rsp_dz    <= 1'b0;
      end
      if (state == DONE) begin
        if (!rsp_valid)     rsp_valid <= 1'b1;
        else if (rsp_ready) rsp_valid <= 1'b0;
      end
    end
  end

  div_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (sel_a),
    .b     (sel_b),
    .done  (core_done),
    .q     (core_q),
    .r     (core_r)
  );

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed scenarios plus randomized
// traffic checked against an arithmetic round-robin/division model.
module tb_div_arbiter;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_a = '0;
  logic [W-1:0] req0_b = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_a = '0;
  logic [W-1:0] req1_b = '0;
  logic         req1_ready;
  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_q;
  logic [W-1:0] rsp_r;
  logic         rsp_dz;
  logic         rsp_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int tb_prio = 0;

  div_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_q      (rsp_q),
    .rsp_r      (rsp_r),
    .rsp_dz     (rsp_dz),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant(bit v0, bit v1);
    if (v0 && v1) return tb_prio;
    return v1 ? 1 : 0;
  endfunction

  function automatic int exp_q(int a, int b);
    return (b == 0) ? 31 : a / b;
  endfunction

  function automatic int exp_r(int a, int b);
    return (b == 0) ? a : a % b;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tb_prio = 0;
  endtask

  // Waits for a ready, lets the accept edge pass, then drops that requester.
  task automatic wait_accept(output int id, output int waits, output bit ok);
    ok = 1'b0;
    id = 0;
    waits = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (req0_ready || req1_ready) begin
        id = req1_ready ? 1 : 0;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      waits++;
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
      tb_prio = (id == 0) ? 1 : 0;
    end
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_txn(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input bit early, output int gid, output int waits, output int lat,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                         output logic rid, output bit ok);
    bit oka, okr;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready = early;
    lat = 0; q = '0; r = '0; dz = 1'b0; rid = 1'b0; okr = 1'b0;
    wait_accept(gid, waits, oka);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (oka) begin
      wait_rsp(lat, okr);
      q = rsp_q; r = rsp_r; dz = rsp_dz; rid = rsp_id;
      if (okr) take_rsp();
    end
    rsp_ready = 1'b0;
    ok = oka && okr;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req0_b = 5'd3;
    req1_valid = 1'b1; req1_b = 5'd3;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, req0_ready, req1_ready} !== '0)
      $display("FAIL reset_outputs: got v=%b id=%b q=%0d r=%0d dz=%b rdy=%b%b, need all 0",
               rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, req0_ready, req1_ready);
    apply_reset();
  endtask

  task automatic test_basic();
    int gid, waits, lat; logic [W-1:0] q, r; logic dz, rid; bit ok;
    run_txn(1, 5'd7, 5'd3, 0, 5'd0, 5'd0, 0, gid, waits, lat, q, r, dz, rid, ok);
    n_cmp++;
    if (!ok) begin
      $display("FAIL basic_timeout: handshake did not complete");
      n_bad++;
      apply_reset();
      return;
    end
    n_cmp++;
    if (waits !== 0) begin
      $display("FAIL basic_first_edge: accept after %0d extra cycles, need 0", waits); n_bad++;
    end
    n_cmp++;
    if (lat !== W) begin $display("FAIL basic_latency: got %0d need %0d", lat, W); n_bad++; end
    n_cmp++;
    if ({rid, q, r, dz} !== {1'b0, 5'd2, 5'd1, 1'b0}) begin
      $display("FAIL basic_result: got id=%b q=%0d r=%0d dz=%b need id=0 q=2 r=1 dz=0",
               rid, q, r, dz);
      n_bad++;
    end
  endtask

  task automatic test_tie();
    int gid, waits, lat; bit ok, okr;
    apply_reset();
    req0_valid = 1'b1; req0_a = 5'd7;  req0_b = 5'd3;
    req1_valid = 1'b1; req1_a = 5'd20; req1_b = 5'd6;
    wait_accept(gid, waits, ok);
    n_cmp++;
    if (!ok || gid !== 0) begin
      $display("FAIL tie_first_grant: got %0d ok=%b need 0", gid, ok); n_bad++;
    end
    wait_rsp(lat, okr);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz} !== {1'b1, 1'b0, 5'd2, 5'd1, 1'b0}) begin
      $display("FAIL tie_rsp0: got v=%b id=%b q=%0d r=%0d need v=1 id=0 q=2 r=1",
               rsp_valid, rsp_id, rsp_q, rsp_r);
      n_bad++;
    end
    n_cmp++;
    if (req0_ready || req1_ready) begin
      $display("FAIL tie_ready_in_done: got %b%b need 00", req0_ready, req1_ready); n_bad++;
    end
    take_rsp();
    wait_accept(gid, waits, ok);
    n_cmp++;
    if (!ok || gid !== 1) begin
      $display("FAIL tie_second_grant: got %0d ok=%b need 1", gid, ok); n_bad++;
    end
    wait_rsp(lat, okr);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz} !== {1'b1, 1'b1, 5'd3, 5'd2, 1'b0}) begin
      $display("FAIL tie_rsp1: got v=%b id=%b q=%0d r=%0d need v=1 id=1 q=3 r=2",
               rsp_valid, rsp_id, rsp_q, rsp_r);
      n_bad++;
    end
    take_rsp();
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_accept(gid, waits, ok);
    req1_valid = 1'b0; req0_valid = 1'b0;
    n_cmp++;
    if (!ok || gid !== 0) begin
      $display("FAIL tie_rr_return: got %0d ok=%b need 0", gid, ok); n_bad++;
    end
    wait_rsp(lat, okr);
    take_rsp();
  endtask

  task automatic test_dz();
    int gid, waits, lat; logic [W-1:0] q, r; logic dz, rid; bit ok;
    run_txn(0, 5'd0, 5'd0, 1, 5'd9, 5'd0, 0, gid, waits, lat, q, r, dz, rid, ok);
    n_cmp++;
    if (!ok || lat !== 1) begin
      $display("FAIL dz_latency: got %0d ok=%b need 1", lat, ok); n_bad++;
    end
    n_cmp++;
    if ({rid, q, r, dz} !== {1'b1, 5'd31, 5'd9, 1'b1}) begin
      $display("FAIL dz_result: got id=%b q=%0d r=%0d dz=%b need id=1 q=31 r=9 dz=1",
               rid, q, r, dz);
      n_bad++;
    end
  endtask

  task automatic test_boundaries();
    int ta[3] = '{31, 3, 0};
    int tbv[3] = '{1, 31, 5};
    int gid, waits, lat; logic [W-1:0] q, r; logic dz, rid; bit ok;
    for (int i = 0; i < 3; i++) begin
      run_txn(1, W'(ta[i]), W'(tbv[i]), 0, 5'd0, 5'd0, 1, gid, waits, lat, q, r, dz, rid, ok);
      n_cmp++;
      if (!ok || int'(q) != exp_q(ta[i], tbv[i]) || int'(r) != exp_r(ta[i], tbv[i]) ||
          dz !== 1'b0 || lat != W) begin
        $display("FAIL boundary_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d need q=%0d r=%0d dz=0 lat=%0d",
                 ta[i], tbv[i], q, r, dz, lat, exp_q(ta[i], tbv[i]), exp_r(ta[i], tbv[i]), W);
        n_bad++;
      end
    end
  endtask

  task automatic test_backpressure();
    int gid, waits, lat; bit ok, okr, stable;
    logic [2*W+2:0] snap;
    int eid;
    req0_valid = 1'b1; req0_a = 5'd20; req0_b = 5'd6;
    wait_accept(gid, waits, ok);
    wait_rsp(lat, okr);
    n_cmp++;
    if (!ok || !okr) begin
      $display("FAIL bp_timeout: accept=%b rsp=%b need 1 1", ok, okr);
      n_bad++;
      apply_reset();
      return;
    end
    snap = {rsp_id, rsp_q, rsp_r, rsp_dz};
    req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd3;
    req1_valid = 1'b1; req1_a = 5'd9; req1_b = 5'd2;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (!rsp_valid || {rsp_id, rsp_q, rsp_r, rsp_dz} !== snap || req0_ready || req1_ready)
        stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin
      $display("FAIL bp_hold: outputs moved or ready raised while stalled (v=%b rdy=%b%b)",
               rsp_valid, req0_ready, req1_ready);
      n_bad++;
    end
    n_cmp++;
    if (snap !== {1'b0, 5'd3, 5'd2, 1'b0}) begin
      $display("FAIL bp_result: got %h need id=0 q=3 r=2 dz=0", snap); n_bad++;
    end
    eid = exp_grant(1, 1);
    take_rsp();
    wait_accept(gid, waits, ok);
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (!ok || gid != eid || waits != 0) begin
      $display("FAIL bp_next_accept: got id=%0d waits=%0d ok=%b need id=%0d waits=0",
               gid, waits, ok, eid);
      n_bad++;
    end
    wait_rsp(lat, okr);
    take_rsp();
  endtask

  task automatic test_reset_mid_run();
    int gid, waits, lat; logic [W-1:0] q, r; logic dz, rid; bit ok, stale;
    req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd3;
    wait_accept(gid, waits, ok);
    @(posedge clk);
    #2;
    reset = 1'b1;
    req1_valid = 1'b1; req1_b = 5'd4;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, req0_ready, req1_ready} !== '0) begin
      $display("FAIL midrun_reset_outputs: got v=%b q=%0d r=%0d rdy=%b%b need all 0",
               rsp_valid, rsp_q, rsp_r, req0_ready, req1_ready);
      n_bad++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req1_valid = 1'b0;
    tb_prio = 0;
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) stale = 1'b1;
    end
    n_cmp++;
    if (stale) begin $display("FAIL midrun_stale: rsp_valid 1 need 0"); n_bad++; end
    run_txn(1, 5'd7, 5'd3, 0, 5'd0, 5'd0, 0, gid, waits, lat, q, r, dz, rid, ok);
    n_cmp++;
    if (!ok || {rid, q, r, dz} !== {1'b0, 5'd2, 5'd1, 1'b0} || lat != W) begin
      $display("FAIL midrun_recover: got id=%b q=%0d r=%0d lat=%0d need id=0 q=2 r=1 lat=%0d",
               rid, q, r, lat, W);
      n_bad++;
    end
  endtask

  task automatic test_random();
    int gid, waits, lat, eid, ea, eb, elat, sel;
    logic [W-1:0] q, r, a0, b0, a1, b1; logic dz, rid; bit ok, v0, v1, early;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(1, 3);
      v0 = sel[0]; v1 = sel[1];
      a0 = W'($urandom_range(0, 31));
      a1 = W'($urandom_range(0, 31));
      b0 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 31));
      b1 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 31));
      early = 1'($urandom_range(0, 1));
      eid = exp_grant(v0, v1);
      ea = (eid == 0) ? int'(a0) : int'(a1);
      eb = (eid == 0) ? int'(b0) : int'(b1);
      elat = (eb == 0) ? 1 : W;
      run_txn(v0, a0, b0, v1, a1, b1, early, gid, waits, lat, q, r, dz, rid, ok);
      n_cmp++;
      if (!ok || gid != eid || int'(rid) != eid || int'(q) != exp_q(ea, eb) ||
          int'(r) != exp_r(ea, eb) || dz !== (eb == 0) || lat != elat) begin
        $display("FAIL random_%0d: got id=%0d/%0d q=%0d r=%0d dz=%b lat=%0d need id=%0d q=%0d r=%0d dz=%0d lat=%0d",
                 n, gid, rid, q, r, dz, lat, eid, exp_q(ea, eb), exp_r(ea, eb), eb == 0, elat);
        n_bad++;
        if (!ok) apply_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_dz();
    test_boundaries();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: WIDTH, default 5, operand/result bit width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a  input  WIDTH  requester 0 dividend.
REQ-006 req0_b  input  WIDTH  requester 0 divisor.
REQ-007 req0_ready  output  1  requester 0 accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready: same directions, widths and meanings for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  1  index of the requester that owns the result.
REQ-011 rsp_q  output  WIDTH  quotient.
REQ-012 rsp_r  output  WIDTH  remainder.
REQ-013 rsp_dz  output  1  divide-by-zero flag.
REQ-014 rsp_ready  input  1  consumer takes the result.

Function
REQ-015 Block SHALL share one iterative unsigned divider between two requesters via valid/ready handshakes.
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 In IDLE, reqN_ready SHALL be driven combinationally high only for the granted requester; both readys SHALL be low in RUN and DONE.
REQ-018 Arbitration: one valid requester SHALL be granted; if both are valid, grant SHALL go to the requester not granted last (round-robin pointer); after reset requester 0 SHALL win the first tie.
REQ-019 Accept (valid & ready at an edge) SHALL latch a, b and id, update the round-robin pointer, and move to RUN with step counter = WIDTH, or to DONE if b == 0.
REQ-020 RUN SHALL perform one restoring shift/subtract step per cycle; after exactly WIDTH steps the FSM SHALL enter DONE.
REQ-021 Latency: rsp_valid SHALL rise WIDTH clock edges after the accept edge (5 for WIDTH=5), or 1 edge after it for b == 0.
REQ-022 Divide by zero: rsp_q SHALL be all ones, rsp_r SHALL equal a, and rsp_dz SHALL be 1; otherwise rsp_dz SHALL be 0, with a = q*b + r and r < b.
REQ-023 In DONE, rsp_valid SHALL be high, and rsp_id/q/r/dz SHALL stay stable until rsp_ready; the rsp_valid & rsp_ready edge SHALL return the FSM to IDLE.
REQ-024 Throughput: the next accept SHALL occur no earlier than the cycle after response handoff; rsp_ready while not in DONE SHALL be ignored.
REQ-025 Request inputs SHALL be ignored outside IDLE; latched operands SHALL NOT change mid-operation.

Reset
REQ-026 Reset SHALL asynchronously force state IDLE, counter 0, round-robin pointer to favour requester 0, and all outputs to 0 (rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, req0_ready, req1_ready).
REQ-027 Reset asserted in RUN or DONE SHALL discard the operation; no response for it SHALL appear after release.
REQ-028 After reset deasserts, the first accept SHALL be possible at the first rising edge.

Structure
REQ-029 Package div_pkg SHALL hold WIDTH, the state enumeration (IDLE/RUN/DONE) and the divide-by-zero quotient constant (all ones).
REQ-030 The per-step restoring arithmetic (partial remainder register, quotient shift, counter) SHALL live in sub-module div_core, with start/done signals; div_arbiter SHALL hold the FSM, arbitration and response registers.

Verification
REQ-031 req0 a=7 b=3 alone -> rsp_valid 5 cycles after accept, rsp_id=0, q=2, r=1, dz=0.
REQ-032 Both valid at the same edge, req0 7/3 and req1 20/6 -> rsp id0 (2,1) first, then id1 (3,2); the next tie grants req0.
REQ-033 req1 a=9 b=0 -> rsp_valid 1 cycle after accept, q=31, r=9, dz=1.
REQ-034 Boundaries 31/1 -> (31,0); 3/31 -> (0,3); 0/5 -> (0,0).
REQ-035 Backpressure: rsp_ready held low 10 cycles in DONE -> outputs stable, both readys low, no new accept.
REQ-036 Reset pulsed 2 cycles into RUN -> all outputs 0 immediately; no stale response; the following 7/3 request completes normally.
